// File: rtl/mmio_io_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mmio_io_pkg
// Description : Shared register offsets and status bit positions for the
//               memory-mapped I/O responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_io_pkg;

    // Word offsets inside the 16-byte window
    localparam logic [3:0] OFF_OUT    = 4'h0;
    localparam logic [3:0] OFF_IN     = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;
    localparam logic [3:0] OFF_TIMER  = 4'hC;

    // STATUS register bit positions
    localparam int ST_CHG   = 0;
    localparam int ST_OVR   = 1;
    localparam int ST_TDONE = 2;

endpackage : mmio_io_pkg
`default_nettype wire

// File: rtl/mmio_io_responder_if.sv
`default_nettype none
// ============================================================================
// Interface   : mmio_io_responder_if
// Description : Processor data-bus view seen by the I/O responder: address,
//               store data, strobes, and the responder's load data and hit.
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_io_responder_if;

    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;

    // Processor side drives the request and consumes the response
    modport master (
        output Address,
        output WriteData,
        output MemWrite,
        output MemRead,
        input  ReadData,
        input  Hit
    );

    // Responder side consumes the request and drives the response
    modport slave (
        input  Address,
        input  WriteData,
        input  MemWrite,
        input  MemRead,
        output ReadData,
        output Hit
    );

endinterface : mmio_io_responder_if
`default_nettype wire

// File: rtl/mmio_io_responder_io_input_sync.sv
`default_nettype none
// ============================================================================
// Module      : io_input_sync
// Description : Two-flop synchronizer for the asynchronous input port plus a
//               delayed copy used to detect changes of the synchronized value.
// Revision    : 1.0 - initial release
// ============================================================================
module io_input_sync #(
    parameter int IN_WIDTH = 8
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic [IN_WIDTH-1:0] port_in,
    output logic      [IN_WIDTH-1:0] in_sync,
    output logic                     change
);

    logic [IN_WIDTH-1:0] in_s1;
    logic [IN_WIDTH-1:0] in_s2;
    logic [IN_WIDTH-1:0] in_prev;

    // Synchronizer chain and one-cycle history of the synchronized value
    always_ff @(posedge clk) begin
        if (reset) begin
            in_s1   <= '0;
            in_s2   <= '0;
            in_prev <= '0;
        end else begin
            in_s1   <= port_in;
            in_s2   <= in_s1;
            in_prev <= in_s2;
        end
    end

    // A change is seen in the cycle where the new value has reached in_s2
    // but not yet in_prev, so the flag logic registers it at the next edge.
    always_comb begin
        in_sync = in_s2;
        change  = (in_s2 != in_prev);
    end

endmodule : io_input_sync
`default_nettype wire

// File: rtl/mmio_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : mmio_io_responder
// Description : Memory-mapped I/O responder in a 16-byte window: output
//               port, synchronized input port, sticky change/overrun flags
//               and a down-counting timer with a done flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_io_responder
    import mmio_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
    parameter int          IN_WIDTH    = 8,
    parameter int          TIMER_WIDTH = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    mmio_io_responder_if.slave        bus,
    input  wire logic [IN_WIDTH-1:0]  PortIn,
    output logic      [31:0]          PortOut,
    output logic                      Irq
);

    logic [3:0]             offset;
    logic                   hit;
    logic                   store;
    logic                   load_side_fx;
    logic                   out_we;
    logic                   timer_we;
    logic                   in_read;

    logic [IN_WIDTH-1:0]    in_sync;
    logic                   change;

    logic                   chg;
    logic                   ovr;
    logic                   tdone;
    logic [TIMER_WIDTH-1:0] count;

    logic [31:0]            in_word;
    logic [31:0]            status_word;
    logic [31:0]            timer_word;

    io_input_sync #(
        .IN_WIDTH (IN_WIDTH)
    ) u_input_sync (
        .clk     (clk),
        .reset   (reset),
        .port_in (PortIn),
        .in_sync (in_sync),
        .change  (change)
    );

    // Address decode and per-register strobes; a simultaneous store
    // suppresses the read side effect (clearing CHG/OVR).
    always_comb begin
        offset       = bus.Address[3:0];
        hit          = (bus.Address[31:4] == BASE_ADDR[31:4]) &&
                       (bus.Address[1:0] == 2'b00);
        store        = bus.MemWrite & hit;
        load_side_fx = bus.MemRead & hit & ~bus.MemWrite;
        out_we       = store & (offset == OFF_OUT);
        timer_we     = store & (offset == OFF_TIMER);
        in_read      = load_side_fx & (offset == OFF_IN);
    end

    // Output port register
    always_ff @(posedge clk) begin
        if (reset) begin
            PortOut <= '0;
        end else if (out_we) begin
            PortOut <= bus.WriteData;
        end
    end

    // Sticky change flag (set beats clear) and overrun flag (clear beats set)
    always_ff @(posedge clk) begin
        if (reset) begin
            chg <= 1'b0;
            ovr <= 1'b0;
        end else begin
            if (change) begin
                chg <= 1'b1;
            end else if (in_read) begin
                chg <= 1'b0;
            end
            if (in_read) begin
                ovr <= 1'b0;
            end else if (change && chg) begin
                ovr <= 1'b1;
            end
        end
    end

    // Down-counter: a store reloads and clears done; otherwise count to zero
    // and flag done on the 1->0 step. Zero is a stopped state.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            tdone <= 1'b0;
        end else if (timer_we) begin
            count <= bus.WriteData[TIMER_WIDTH-1:0];
            tdone <= 1'b0;
        end else if (count != '0) begin
            count <= count - TIMER_WIDTH'(1);
            if (count == TIMER_WIDTH'(1)) begin
                tdone <= 1'b1;
            end
        end
    end

    // Zero-extended register images for the read mux
    always_comb begin
        in_word                       = '0;
        in_word[IN_WIDTH-1:0]         = in_sync;
        status_word                   = '0;
        status_word[ST_CHG]           = chg;
        status_word[ST_OVR]           = ovr;
        status_word[ST_TDONE]         = tdone;
        timer_word                    = '0;
        timer_word[TIMER_WIDTH-1:0]   = count;
    end

    // Combinational read mux; zero outside the window
    always_comb begin
        bus.ReadData = '0;
        bus.Hit      = hit;
        if (hit) begin
            case (offset)
                OFF_OUT:    bus.ReadData = PortOut;
                OFF_IN:     bus.ReadData = in_word;
                OFF_STATUS: bus.ReadData = status_word;
                OFF_TIMER:  bus.ReadData = timer_word;
                default:    bus.ReadData = '0;
            endcase
        end
    end

    // Interrupt straight from the registered flags
    always_comb begin
        Irq = chg | tdone;
    end

endmodule : mmio_io_responder
`default_nettype wire

// File: tb/tb_mmio_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_io_responder
// Description : Directed self-checking bench for mmio_io_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_io_responder;

    logic        clk;
    logic        reset;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
    logic        Irq;

    int checks;
    int errors;

    mmio_io_responder_if bus ();

    mmio_io_responder #(
        .BASE_ADDR   (32'hFFFF_0000),
        .IN_WIDTH    (8),
        .TIMER_WIDTH (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .PortIn  (PortIn),
        .PortOut (PortOut),
        .Irq     (Irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the bus; outputs settle before the caller samples
    task automatic drive(input logic [31:0] addr, input logic [31:0] data,
                         input logic we, input logic re);
        bus.Address   = addr;
        bus.WriteData = data;
        bus.MemWrite  = we;
        bus.MemRead   = re;
        #1;
    endtask

    task automatic idle();
        drive(32'h0000_0000, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        PortIn = 8'h00;
        idle();
        tick();
        tick();
        reset = 1'b0;
        checks++; if (PortOut !== 32'h0) begin errors++; $display("FAIL reset_portout got %h want %h", PortOut, 32'h0); end
        checks++; if (Irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", Irq); end
        drive(32'hFFFF_0008, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL reset_status got %h want %h", bus.ReadData, 32'h0); end
        drive(32'hFFFF_000C, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL reset_timer got %h want %h", bus.ReadData, 32'h0); end
        idle();
    endtask

    task automatic test_out();
        drive(32'hFFFF_0000, 32'hDEAD_BEEF, 1'b1, 1'b0);
        checks++; if (PortOut !== 32'h0) begin errors++; $display("FAIL out_pre_edge got %h want %h", PortOut, 32'h0); end
        tick();
        idle();
        checks++; if (PortOut !== 32'hDEAD_BEEF) begin errors++; $display("FAIL out_latch got %h want %h", PortOut, 32'hDEAD_BEEF); end
        drive(32'hFFFF_0000, 32'h0, 1'b0, 1'b1);
        checks++; if (bus.ReadData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL out_read got %h want %h", bus.ReadData, 32'hDEAD_BEEF); end
        checks++; if (bus.Hit !== 1'b1) begin errors++; $display("FAIL out_hit got %b want 1", bus.Hit); end
        idle();
    endtask

    task automatic test_in_sync();
        PortIn = 8'h5A;
        tick();
        drive(32'hFFFF_0004, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL in_edge0 got %h want %h", bus.ReadData, 32'h0); end
        tick();
        checks++; if (bus.ReadData !== 32'h5A) begin errors++; $display("FAIL in_edge1 got %h want %h", bus.ReadData, 32'h5A); end
        checks++; if (Irq !== 1'b0) begin errors++; $display("FAIL in_irq_edge1 got %b want 0", Irq); end
        tick();
        drive(32'hFFFF_0008, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.ReadData !== 32'h1) begin errors++; $display("FAIL chg_set got %h want %h", bus.ReadData, 32'h1); end
        checks++; if (Irq !== 1'b1) begin errors++; $display("FAIL chg_irq got %b want 1", Irq); end
        drive(32'hFFFF_0004, 32'h0, 1'b0, 1'b1);
        tick();
        drive(32'hFFFF_0008, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL chg_clear got %h want %h", bus.ReadData, 32'h0); end
        checks++; if (Irq !== 1'b0) begin errors++; $display("FAIL chg_clear_irq got %b want 0", Irq); end
        idle();
    endtask

    task automatic test_ovr();
        PortIn = 8'hA5;
        tick(); tick(); tick();
        PortIn = 8'h3C;
        tick(); tick(); tick();
        drive(32'hFFFF_0008, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.ReadData !== 32'h3) begin errors++; $display("FAIL ovr_set got %h want %h", bus.ReadData, 32'h3); end
        PortIn = 8'h11;
        tick(); tick();
        // change pulse is live in this cycle; the clearing read collides with it
        drive(32'hFFFF_0004, 32'h0, 1'b0, 1'b1);
        checks++; if (bus.ReadData !== 32'h11) begin errors++; $display("FAIL ovr_in_value got %h want %h", bus.ReadData, 32'h11); end
        tick();
        drive(32'hFFFF_0008, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.ReadData !== 32'h1) begin errors++; $display("FAIL set_beats_clear got %h want %h", bus.ReadData, 32'h1); end
        drive(32'hFFFF_0004, 32'h0, 1'b0, 1'b1);
        tick();
        drive(32'hFFFF_0008, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL ovr_cleanup got %h want %h", bus.ReadData, 32'h0); end
        idle();
    endtask

    task automatic test_timer();
        logic [31:0] exp_cnt [4];
        exp_cnt[0] = 32'd3; exp_cnt[1] = 32'd2; exp_cnt[2] = 32'd1; exp_cnt[3] = 32'd0;
        drive(32'hFFFF_000C, 32'd3, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(32'hFFFF_000C, 32'h0, 1'b0, 1'b0);
            checks++; if (bus.ReadData !== exp_cnt[i]) begin errors++; $display("FAIL timer_count[%0d] got %h want %h", i, bus.ReadData, exp_cnt[i]); end
            drive(32'hFFFF_0008, 32'h0, 1'b0, 1'b0);
            checks++; if (bus.ReadData !== ((i == 3) ? 32'h4 : 32'h0)) begin errors++; $display("FAIL timer_tdone[%0d] got %h want %h", i, bus.ReadData, ((i == 3) ? 32'h4 : 32'h0)); end
            if (i < 3) tick();
        end
        tick();
        drive(32'hFFFF_000C, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL timer_no_wrap got %h want %h", bus.ReadData, 32'h0); end
        checks++; if (Irq !== 1'b1) begin errors++; $display("FAIL tdone_sticky_irq got %b want 1", Irq); end
        drive(32'hFFFF_000C, 32'd2, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        drive(32'hFFFF_000C, 32'd5, 1'b1, 1'b0);
        checks++; if (bus.ReadData !== 32'd1) begin errors++; $display("FAIL timer_expiring got %h want %h", bus.ReadData, 32'd1); end
        tick();
        drive(32'hFFFF_000C, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.ReadData !== 32'd5) begin errors++; $display("FAIL store_wins_count got %h want %h", bus.ReadData, 32'd5); end
        drive(32'hFFFF_0008, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL store_wins_tdone got %h want %h", bus.ReadData, 32'h0); end
        drive(32'hFFFF_000C, 32'd0, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        drive(32'hFFFF_000C, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL timer_stop got %h want %h", bus.ReadData, 32'h0); end
        checks++; if (Irq !== 1'b0) begin errors++; $display("FAIL timer_stop_irq got %b want 0", Irq); end
        idle();
    endtask

    task automatic test_no_hit();
        drive(32'hFFFF_0004, 32'h1234_5678, 1'b1, 1'b0);
        tick();
        drive(32'hFFFF_0002, 32'h8765_4321, 1'b1, 1'b0);
        checks++; if (bus.Hit !== 1'b0) begin errors++; $display("FAIL unaligned_hit got %b want 0", bus.Hit); end
        checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL unaligned_data got %h want %h", bus.ReadData, 32'h0); end
        tick();
        drive(32'h1000_0000, 32'h0, 1'b0, 1'b1);
        checks++; if (bus.Hit !== 1'b0) begin errors++; $display("FAIL outside_hit got %b want 0", bus.Hit); end
        checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL outside_data got %h want %h", bus.ReadData, 32'h0); end
        tick();
        idle();
        checks++; if (PortOut !== 32'hDEAD_BEEF) begin errors++; $display("FAIL nohit_portout got %h want %h", PortOut, 32'hDEAD_BEEF); end
        drive(32'hFFFF_0008, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL nohit_status got %h want %h", bus.ReadData, 32'h0); end
        idle();
    endtask

    task automatic test_rw_both();
        PortIn = 8'h77;
        tick(); tick(); tick();
        drive(32'hFFFF_0004, 32'hFFFF_FFFF, 1'b1, 1'b1);
        checks++; if (bus.ReadData !== 32'h77) begin errors++; $display("FAIL rw_in_value got %h want %h", bus.ReadData, 32'h77); end
        tick();
        drive(32'hFFFF_0008, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.ReadData !== 32'h1) begin errors++; $display("FAIL rw_no_clear got %h want %h", bus.ReadData, 32'h1); end
        drive(32'hFFFF_0000, 32'hCAFE_F00D, 1'b1, 1'b1);
        checks++; if (bus.ReadData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rw_pre_edge got %h want %h", bus.ReadData, 32'hDEAD_BEEF); end
        tick();
        idle();
        checks++; if (PortOut !== 32'hCAFE_F00D) begin errors++; $display("FAIL rw_store got %h want %h", PortOut, 32'hCAFE_F00D); end
    endtask

    task automatic test_reset_mid();
        drive(32'hFFFF_000C, 32'd7, 1'b1, 1'b0);
        tick();
        idle();
        checks++; if (Irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %b want 1", Irq); end
        reset = 1'b1;
        tick();
        checks++; if (PortOut !== 32'h0) begin errors++; $display("FAIL mid_reset_portout got %h want %h", PortOut, 32'h0); end
        checks++; if (Irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq got %b want 0", Irq); end
        drive(32'hFFFF_000C, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL mid_reset_timer got %h want %h", bus.ReadData, 32'h0); end
        drive(32'hFFFF_0008, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL mid_reset_status got %h want %h", bus.ReadData, 32'h0); end
        drive(32'hFFFF_0004, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL mid_reset_in got %h want %h", bus.ReadData, 32'h0); end
        reset = 1'b0;
        idle();
    endtask

    // Scenario sequence
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_out();
        test_in_sync();
        test_ovr();
        test_timer();
        test_no_hit();
        test_rw_both();
        test_reset_mid();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mmio_io_responder
`default_nettype wire
